// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned FRAME_BITS  = 10;
  localparam int unsigned DATA_BITS   = 8;
  // Index of the last data bit: frame length minus start and stop bits, minus one.
  localparam int unsigned DATA_LAST   = FRAME_BITS - 3;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned LEVEL_OUT_W = 5;

  // Board-level debug word: {frames sent, last byte popped, 3'b0, FIFO level}.
  typedef struct packed {
    logic [COUNT_W-1:0]     count;
    logic [DATA_BITS-1:0]   last;
    logic [2:0]             rsvd;
    logic [LEVEL_OUT_W-1:0] level;
  } tx_check_t;

  function automatic tx_check_t pack_check(
    input logic [COUNT_W-1:0]     count,
    input logic [DATA_BITS-1:0]   last,
    input logic [LEVEL_OUT_W-1:0] level
  );
    tx_check_t c;
    c.count = count;
    c.last  = last;
    c.rsvd  = 3'b000;
    c.level = level;
    return c;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with registered level/full/empty and a show-ahead head.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_nxt;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head of queue is visible before the pop so the consumer can latch it on the pop edge.
  assign pop_data_c = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Pointers and occupancy flags; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a byte FIFO and debug check word.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        tx,
  output logic        overflow,
  output logic [31:0] tx_check
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LAST);

  tx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [COUNT_W-1:0]   tx_count;
  logic [DATA_BITS-1:0] tx_last;
  logic [LVL_W-1:0]     level;
  logic [DATA_BITS-1:0] head_c;
  logic                 pop_c;
  logic                 bit_done_c;

  // A new frame starts whenever the line is idle and a byte is waiting.
  assign pop_c      = (state == IDLE) && !empty;
  assign bit_done_c = (baud_cnt == CNT_LAST);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (wr_en),
    .push_data  (wr_data),
    .pop        (pop_c),
    .pop_data_c (head_c),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  // Frame sequencer: tx and busy are registered from the current state, one cycle behind it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_count <= '0;
      tx_last  <= '0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop_c) begin
            shift   <= head_c;
            tx_last <= head_c;
            state   <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_done_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          tx <= shift[bit_idx];
          if (bit_done_c) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_done_c) begin
            baud_cnt <= '0;
            tx_count <= tx_count + COUNT_W'(1);
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Sticky record of any write dropped because the FIFO was full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  assign tx_check = pack_check(tx_count, tx_last, LEVEL_OUT_W'(level));

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: queue-level reference model, frame-decoding monitor.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int          FRAME = int'(FRAME_BITS * CPB);

  logic        clk;
  logic        reset;
  logic        wr_en, wr_en1;
  logic [7:0]  wr_data, wr_data1;
  logic        full, empty, busy, tx, overflow;
  logic        full1, empty1, busy1, tx1, overflow1;
  logic [31:0] tx_check, tx_check1;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .tx(tx),
    .overflow(overflow), .tx_check(tx_check)
  );

  uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1),
    .full(full1), .empty(empty1), .busy(busy1), .tx(tx1),
    .overflow(overflow1), .tx_check(tx_check1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=0x%0h want=0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO as a byte queue, transmitter as "time of last pop".
  int          cyc = 0;
  logic [7:0]  mq[$];
  logic [7:0]  sb_q[$];
  int          st_q[$];
  bit          m_act = 1'b0;
  int          m_p = 0;
  logic [15:0] m_count = '0;
  logic [7:0]  m_last = '0;
  bit          m_ovf = 1'b0;

  task automatic model_clear();
    mq.delete();
    sb_q.delete();
    st_q.delete();
    m_act   = 1'b0;
    m_p     = 0;
    m_count = '0;
    m_last  = '0;
    m_ovf   = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        model_clear();
      end else begin
        bit pop;
        bit fullp;
        cyc++;
        pop   = (!m_act || cyc >= m_p + FRAME + 1) && (mq.size() > 0);
        fullp = (mq.size() == int'(DEPTH));
        if (m_act && cyc == m_p + FRAME) m_count++;
        if (wr_en && fullp) m_ovf = 1'b1;
        if (pop) begin
          m_last = mq.pop_front();
          m_p    = cyc;
          m_act  = 1'b1;
          st_q.push_back(cyc + 1);
        end
        if (wr_en && !fullp) begin
          mq.push_back(wr_data);
          sb_q.push_back(wr_data);
        end
      end
    end
  end

  // Status checker: compares the registered status outputs every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        bit exp_busy;
        exp_busy = m_act && (cyc - 1 >= m_p) && (cyc - 1 < m_p + FRAME);
        check("busy",     32'(busy),            32'(exp_busy));
        check("level",    32'(tx_check[4:0]),   32'(mq.size()));
        check("full",     32'(full),            32'(mq.size() == int'(DEPTH)));
        check("empty",    32'(empty),           32'(mq.size() == 0));
        check("overflow", 32'(overflow),        32'(m_ovf));
        check("tx_count", 32'(tx_check[31:16]), 32'(m_count));
        check("tx_last",  32'(tx_check[15:8]),  32'(m_last));
        check("rsvd",     32'(tx_check[7:5]),   32'(0));
      end
    end
  end

  // Monitor: decodes frames on tx and pops the scoreboard on each start bit.
  bit         mon_on = 1'b0;
  int         mon_s = 0;
  logic [7:0] mon_byte = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_on = 1'b0;
      end else if (!mon_on) begin
        if (tx === 1'b0) begin
          mon_on = 1'b1;
          mon_s  = 0;
          if (st_q.size() == 0 || sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start t=%0t got=start_bit want=idle_line", $time);
            mon_byte = 8'hFF;
          end else begin
            check("start_time", 32'(cyc), 32'(st_q.pop_front()));
            mon_byte = sb_q.pop_front();
          end
        end
      end else begin
        int   b;
        logic expbit;
        mon_s++;
        b = mon_s / int'(CPB);
        if (b == 0)      expbit = 1'b0;
        else if (b <= 8) expbit = mon_byte[b-1];
        else             expbit = 1'b1;
        check("tx_bit", 32'(tx), 32'(expbit));
        if (mon_s == FRAME - 1) mon_on = 1'b0;
      end
    end
  end

  task automatic put(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (mq.size() == 0 && (!m_act || cyc >= m_p + FRAME + 2) && !mon_on) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s t=%0t got=still_busy want=drained_within_%0d", name, $time, max_cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=no_finish want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b81;
    int         bcnt;
    wr_en = 1'b0; wr_data = '0; wr_en1 = 1'b0; wr_data1 = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",       32'(tx),       32'(1));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_full",     32'(full),     32'(0));
    check("rst_empty",    32'(empty),    32'(1));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_check",    tx_check,      32'h0);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte
    put(8'h55);
    wait_drain(200, "t1_drain");
    check("t1_count", 32'(tx_check[31:16]), 32'(1));
    check("t1_last",  32'(tx_check[15:8]),  32'h55);

    // Back-to-back pair
    put(8'hA5);
    put(8'h3C);
    wait_drain(200, "t2_drain");
    check("t2_count", 32'(tx_check[31:16]), 32'(3));

    // Fill the FIFO, then one write too many
    for (int i = 0; i < 18; i++) put(8'($urandom));
    check("t3_overflow", 32'(overflow),       32'(1));
    check("t3_level",    32'(tx_check[4:0]),  32'(16));
    check("t3_full",     32'(full),           32'(1));
    wait_drain(17 * (FRAME + 1) + 100, "t3_drain");
    check("t3_count",    32'(tx_check[31:16]), 32'(20));
    check("t3_sticky",   32'(overflow),        32'(1));

    // Push coinciding with a pop at level 3
    for (int i = 0; i < 4; i++) put(8'($urandom));
    repeat (38) @(negedge clk);
    put(8'($urandom));
    check("t4_level", 32'(tx_check[4:0]), 32'(3));
    wait_drain(6 * (FRAME + 1) + 100, "t4_drain");
    check("t4_count", 32'(tx_check[31:16]), 32'(25));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 24) == 0);
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_drain(17 * (FRAME + 1) + 100, "rnd_drain");

    // Reset during data bit 3 of 0xFF with two bytes queued
    put(8'hFF);
    put(8'($urandom));
    put(8'($urandom));
    repeat (17) @(negedge clk);
    check("t5_level_pre", 32'(tx_check[4:0]), 32'(2));
    check("t5_busy_pre",  32'(busy),          32'(1));
    #2 reset = 1'b0;
    #1;
    check("t5_tx",       32'(tx),       32'(1));
    check("t5_busy",     32'(busy),     32'(0));
    check("t5_empty",    32'(empty),    32'(1));
    check("t5_overflow", 32'(overflow), 32'(0));
    check("t5_check",    tx_check,      32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("t5_empty_post", 32'(empty),    32'(1));
    check("t5_busy_post",  32'(busy),     32'(0));
    check("t5_check_post", tx_check,      32'h0);

    // Reset while the start bit is low must raise tx immediately
    put(8'($urandom));
    repeat (3) @(negedge clk);
    check("t5b_start_low", 32'(tx), 32'(0));
    #2 reset = 1'b0;
    #1;
    check("t5b_tx_async", 32'(tx), 32'(1));
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    // One clock per bit
    b81      = 8'h81;
    wr_en1   = 1'b1;
    wr_data1 = b81;
    @(negedge clk);
    wr_en1 = 1'b0;
    bcnt   = 0;
    for (int i = 1; i <= 14; i++) begin
      int   pos;
      logic e;
      @(negedge clk);
      pos = i - 2;
      if (pos == 0)                 e = 1'b0;
      else if (pos >= 1 && pos <= 8) e = b81[pos-1];
      else                          e = 1'b1;
      check("t6_tx", 32'(tx1), 32'(e));
      if (busy1) bcnt++;
    end
    check("t6_busy_cycles", 32'(bcnt),               32'(10));
    check("t6_count",       32'(tx_check1[31:16]),   32'(1));
    check("t6_last",        32'(tx_check1[15:8]),    32'h81);
    check("t6_empty",       32'(empty1),             32'(1));
    check("t6_full",        32'(full1),              32'(0));
    check("t6_overflow",    32'(overflow1),          32'(0));

    wait_drain(200, "final_drain");
    check("sb_empty", 32'(sb_q.size()), 32'(0));
    check("st_empty", 32'(st_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
